// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: serial key expansion, one inverse round per clock.
// Optional AES_DEC_KEY_REUSE_EN: skip key expansion when the key matches the last fully expanded key.
module aes_decrypt_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_text,
    output logic         busy
);

    if (NR != 10) begin : g_nr_check
        $error("aes_decrypt_iter supports only NR=10");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {
        S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL, S_DONE
    } state_t;

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        return SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] m2, m4, m8;
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            m2    = xtime(a[i]);
            m4    = xtime(m2);
            m8    = xtime(m4);
            m9[i] = m8 ^ a[i];
            mb[i] = m8 ^ m2 ^ a[i];
            md[i] = m8 ^ m4 ^ a[i];
            me[i] = m8 ^ m4 ^ m2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         r_state, w_next;
    logic [127:0]   r_ct, r_s, r_pt;
    logic [127:0]   r_rk [0:10];
    logic [3:0]     r_ctr;
    logic           r_out_valid;
    logic           w_accept, w_reuse;
    logic [127:0]   w_isr, w_isb, w_ark, w_imc, w_prev, w_kexp;
    logic [31:0]    w_temp;

    // Shared round datapath; in FINAL the counter has reached 0, so rk[r_ctr] selects rk[0].
    always_comb begin
        w_isr = '0;
        w_isb = '0;
        w_imc = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                w_isr[127-8*(r+4*c) -: 8] = r_s[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        for (int unsigned i = 0; i < 16; i++) begin
            w_isb[127-8*i -: 8] = inv_sbox(w_isr[127-8*i -: 8]);
        end
        w_ark = w_isb ^ r_rk[r_ctr];
        for (int unsigned c = 0; c < 4; c++) begin
            w_imc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
        end
    end

    always_comb begin
        w_prev = r_rk[r_ctr - 4'd1];
        w_temp = {fwd_sbox(w_prev[23:16]), fwd_sbox(w_prev[15:8]),
                  fwd_sbox(w_prev[7:0]),   fwd_sbox(w_prev[31:24])} ^ {rcon(r_ctr), 24'h0};
        w_kexp[127:96] = w_prev[127:96] ^ w_temp;
        w_kexp[95:64]  = w_prev[95:64]  ^ w_kexp[127:96];
        w_kexp[63:32]  = w_prev[63:32]  ^ w_kexp[95:64];
        w_kexp[31:0]   = w_prev[31:0]   ^ w_kexp[63:32];
    end

    always_comb begin
        w_next   = r_state;
        in_ready = (r_state == S_IDLE) && !rst;
        busy     = 1'b0;
        w_accept = in_valid && in_ready;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_reuse ? S_INIT : S_KEYEXP;
            S_KEYEXP: begin
                busy = 1'b1;
                if (r_ctr == 4'd10) w_next = S_INIT;
            end
            S_INIT:   begin
                busy   = 1'b1;
                w_next = S_ROUND;
            end
            S_ROUND:  begin
                busy = 1'b1;
                if (r_ctr == 4'd1) w_next = S_FINAL;
            end
            S_FINAL:  begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE:   if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

`ifdef AES_DEC_KEY_REUSE_EN
    logic [127:0] r_key_q;
    logic         r_key_ok;

    assign w_reuse = r_key_ok && (key == r_key_q);

    // key_ok drops on every fresh accept so an aborted expansion never marks rk as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_q  <= '0;
            r_key_ok <= 1'b0;
        end else if (w_accept) begin
            r_key_q  <= key;
            r_key_ok <= w_reuse;
        end else if (r_state == S_KEYEXP && r_ctr == 4'd10) begin
            r_key_ok <= 1'b1;
        end
    end
`else
    assign w_reuse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ctr       <= '0;
            r_out_valid <= 1'b0;
            r_pt        <= '0;
            r_ct        <= '0;
            r_s         <= '0;
            for (int unsigned i = 0; i < 11; i++) r_rk[i] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_ct    <= cipher;
                    r_rk[0] <= key;
                    r_ctr   <= 4'd1;
                end
                S_KEYEXP: begin
                    r_rk[r_ctr] <= w_kexp;
                    if (r_ctr != 4'd10) r_ctr <= r_ctr + 4'd1;
                end
                S_INIT: begin
                    r_s   <= r_ct ^ r_rk[10];
                    r_ctr <= 4'd9;
                end
                S_ROUND: begin
                    r_s   <= w_imc;
                    r_ctr <= r_ctr - 4'd1;
                end
                S_FINAL: begin
                    r_pt        <= w_ark;
                    r_out_valid <= 1'b1;
                end
                S_DONE: if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign plain_text = r_pt;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: known vectors, back-pressure, reset abort,
// and random round-trips through an in-bench AES-128 encryption model.
module tb_aes_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready;
    logic [127:0] cipher, key;
    logic         in_ready, out_valid, busy;
    logic [127:0] plain_text;

    always #5 clk = ~clk;

    aes_decrypt_iter #(.NR(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cipher(cipher), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .plain_text(plain_text), .busy(busy)
    );

`ifdef AES_DEC_KEY_REUSE_EN
    localparam int LAT_REUSE = 12;
`else
    localparam int LAT_REUSE = 22;
`endif
    localparam int LAT_FULL = 22;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] k;
        logic [127:0] c;
        logic [127:0] p;
        int           lat;
    } vec_t;

    int         n_run = 0;
    int         n_fail = 0;
    logic [7:0] m_sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine transform.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = 8'h63;
            for (int r = 0; r < 5; r++)
                s = s ^ ((inv << r) | (inv >> (8 - r)));
            m_sb[x] = s;
        end
    endtask

    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   w [176];
        logic [7:0]   tmp [4];
        logic [7:0]   a [4];
        logic [7:0]   rc, u;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                u      = tmp[0];
                tmp[0] = m_sb[tmp[1]] ^ rc;
                tmp[1] = m_sb[tmp[2]];
                tmp[2] = m_sb[tmp[3]];
                tmp[3] = m_sb[u];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = m_sb[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                    s[4*c]   = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
                    s[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic do_accept(input logic [127:0] k, input logic [127:0] c);
        int n = 0;
        @(negedge clk);
        key = k; cipher = c; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_int("accept_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; key = ~k; cipher = ~c;
    endtask

    // Edge n after the accept edge is the first one sampling out_valid high.
    task automatic wait_out(output logic [127:0] got, output int lat);
        int hs_ok = 1;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
            if (!busy || in_ready) hs_ok = 0;
        end
        got = plain_text;
        chk_int("busy_while_running", hs_ok, 1);
        chk_int("busy_low_in_done", int'(busy), 0);
    endtask

    task automatic take(input logic [127:0] got, input int hold, input bit preload,
                        input logic [127:0] pk, input logic [127:0] pc);
        int ok = 1;
        for (int i = 0; i < hold; i++) begin
            if (preload) begin
                in_valid = 1'b1; key = pk; cipher = pc;
            end
            @(negedge clk);
            if (plain_text !== got || !out_valid || in_ready || busy) ok = 0;
        end
        if (hold > 0) chk_int("backpressure_stable", ok, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk_int("out_valid_after_take", int'(out_valid), 0);
    endtask

    task automatic run_vec(input string nm, input vec_t v, input int hold);
        logic [127:0] got;
        int           lat;
        do_accept(v.k, v.c);
        wait_out(got, lat);
        chk({nm, "_pt"}, got, v.p);
        chk_int({nm, "_lat"}, lat, v.lat);
        take(got, hold, 1'b0, '0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t         tbl [6];
        vec_t         v;
        logic [127:0] got, prev_k, rk, rp;
        int           lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cipher = '0; key = '0;
        build_sbox();
        chk("model_fips_c1", enc(P1, K1), C1);
        chk("model_fips_b", enc(P2, K2), C2);

        tbl[0] = '{k: K1, c: C1, p: P1, lat: LAT_FULL};
        tbl[1] = '{k: K2, c: C2, p: P2, lat: LAT_FULL};
        for (int i = 2; i < 6; i++) begin
            tbl[i].k   = {$urandom(), $urandom(), $urandom(), $urandom()};
            tbl[i].p   = {$urandom(), $urandom(), $urandom(), $urandom()};
            tbl[i].c   = enc(tbl[i].p, tbl[i].k);
            tbl[i].lat = LAT_FULL;
        end

        repeat (3) @(posedge clk);
        #1;
        chk_int("rst_out_valid", int'(out_valid), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_in_ready", int'(in_ready), 0);
        chk("rst_plain_text", plain_text, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_int("in_ready_after_rst", int'(in_ready), 1);

        // Same key twice, then a new key.
        run_vec("kr_first", tbl[0], 0);
        v = tbl[0]; v.lat = LAT_REUSE;
        run_vec("kr_repeat", v, 0);
        run_vec("kr_newkey", tbl[1], 0);

        for (int i = 0; i < 6; i++) run_vec($sformatf("tbl%0d", i), tbl[i], i % 3);

        // Back-pressure with the next block already presented.
        do_accept(K1, C1);
        wait_out(got, lat);
        chk("bp_pt", got, P1);
        chk_int("bp_lat", lat, LAT_FULL);
        take(got, 15, 1'b1, K2, C2);
        chk_int("bp_in_ready_idle", int'(in_ready), 1);
        run_vec("bp_next", tbl[1], 0);

        // Reset abort after key expansion, then rerun.
        do_accept(K1, C1);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_int("abort_out_valid", int'(out_valid), 0);
        chk_int("abort_busy", int'(busy), 0);
        chk_int("abort_in_ready_rst", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_int("abort_in_ready", int'(in_ready), 1);
        run_vec("abort_rerun", tbl[0], 0);

        // Reset inside key expansion, then the same key must expand again.
        do_accept(K2, C2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_int("abort_kexp_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("abort_kexp_rerun", tbl[1], 0);

        prev_k = K2;
        for (int i = 0; i < 20; i++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (rk == prev_k) rk[0] = ~rk[0];
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            v  = '{k: rk, c: enc(rp, rk), p: rp, lat: LAT_FULL};
            run_vec($sformatf("rand%0d", i), v, int'($urandom_range(0, 3)));
            prev_k = rk;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
